sw_debounce: RTL and testbench

Synchronizes and debounces the 16 board slide switches before their value reaches the BCD-to-binary converters and the CPU operand port. Each switch bit passes through a two-flop synchronizer and its own stability counter; a bit's output changes only after its input has held a new level for CNT_MAX consecutive cycles. The block also gives a one-cycle `changed` strobe when any output bit flips, and a per-nibble BCD-validity flag, so downstream logic can latch operands only when they are stable and legal.

---
 rtl/sw_debounce.sv | 68 ++++++
 tb/tb_sw_debounce.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchronizer plus per-bit stability counter for the
// board slide switches. Also emits a one-cycle change strobe and a per-nibble
// BCD-legal flag registered alongside the debounced value.
module sw_debounce #(
  parameter int N       = 16,
  parameter int CNT_MAX = 1000000
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   sw_in,
  output logic [N-1:0]   sw_out,
  output logic           changed,
  output logic [N/4-1:0] bcd_ok
);

  localparam int            CW   = $clog2(CNT_MAX);
  localparam logic [CW-1:0] TERM = CW'(CNT_MAX - 1);

  logic [N-1:0]   sw_nxt;
  logic [N-1:0]   flip;
  logic [N/4-1:0] bcd_nxt;

  for (genvar b = 0; b < N; b++) begin : g_bit
    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          mis, term;

    assign mis       = s2 ^ sw_out[b];
    assign term      = (cnt == TERM);
    assign flip[b]   = mis & term;
    assign sw_nxt[b] = sw_out[b] ^ flip[b];

    // Sync chain and stability count; any match (even one cycle) restarts the count
    always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
        s1  <= 1'b0;
        s2  <= 1'b0;
        cnt <= '0;
      end else begin
        s1 <= sw_in[b];
        s2 <= s1;
        if (!mis || term) cnt <= '0;
        else              cnt <= cnt + CW'(1);
      end
    end
  end

  // BCD legality is derived from the next-state value so it lands with sw_out
  always_comb begin
    bcd_nxt = '1;
    for (int i = 0; i < N/4; i++)
      bcd_nxt[i] = (sw_nxt[4*i +: 4] <= 4'd9);
  end

  // Debounced outputs, change strobe and BCD flags all update on the same edge
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sw_out  <= '0;
      changed <= 1'b0;
      bcd_ok  <= '1;
    end else begin
      sw_out  <= sw_nxt;
      changed <= |flip;
      bcd_ok  <= bcd_nxt;
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with N=16, CNT_MAX=4. Each stimulus step pushes the
// expected settle cycle and output values; they are popped when changed fires.
module tb_sw_debounce;
  localparam int N   = 16;
  localparam int CM  = 4;
  localparam int LAT = CM + 1;

  logic           clk = 1'b0;
  logic           clr;
  logic [N-1:0]   sw_in;
  logic [N-1:0]   sw_out;
  logic           changed;
  logic [N/4-1:0] bcd_ok;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int             due;
    logic [N-1:0]   sw;
    logic [N/4-1:0] ok;
  } exp_t;
  exp_t sbq[$];

  sw_debounce #(.N(N), .CNT_MAX(CM)) u_dut (
    .clk     (clk),
    .clr     (clr),
    .sw_in   (sw_in),
    .sw_out  (sw_out),
    .changed (changed),
    .bcd_ok  (bcd_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive a new level just before the next edge and queue its expected settle
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] esw, input logic [N/4-1:0] eok);
    exp_t e;
    @(negedge clk);
    sw_in = v;
    e.due = cyc + 1 + LAT;
    e.sw  = esw;
    e.ok  = eok;
    sbq.push_back(e);
  endtask

  // Bounded wait for the change strobe; reports where it was seen
  task automatic wait_changed(output int at, output bit hit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!changed && n < 50);
    hit = changed;
    at  = cyc;
  endtask

  task automatic test_reset();
    exp_t e; int at; bit hit;
    clr = 1'b1; sw_in = '1;
    repeat (3) @(negedge clk);
    total++; if (sw_out !== 16'h0000) begin bad++; $display("FAIL rst_sw got=%h want=0000", sw_out); end
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL rst_changed got=%b want=0", changed); end
    total++; if (bcd_ok !== 4'hF) begin bad++; $display("FAIL rst_bcd got=%h want=F", bcd_ok); end
    @(negedge clk);
    clr = 1'b0;
    e.due = cyc + 1 + LAT; e.sw = 16'hFFFF; e.ok = 4'h0;
    sbq.push_back(e);
    e = sbq.pop_front();
    wait_changed(at, hit);
    total++; if (!hit || at !== e.due) begin bad++; $display("FAIL rel_when got=%0d hit=%0b want=%0d", at, hit, e.due); end
    total++; if (sw_out !== e.sw) begin bad++; $display("FAIL rel_sw got=%h want=%h", sw_out, e.sw); end
    total++; if (bcd_ok !== e.ok) begin bad++; $display("FAIL rel_bcd got=%h want=%h", bcd_ok, e.ok); end
    @(negedge clk);
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL rel_pulse got=%b want=0", changed); end
  endtask

  task automatic test_glitch();
    exp_t e; int at; bit hit; int pulses = 0; int mx = 0;
    drive(16'h0000, 16'h0000, 4'hF);
    e = sbq.pop_front();
    wait_changed(at, hit);
    total++; if (!hit || at !== e.due) begin bad++; $display("FAIL zero_when got=%0d hit=%0b want=%0d", at, hit, e.due); end
    total++; if (sw_out !== e.sw) begin bad++; $display("FAIL zero_sw got=%h want=%h", sw_out, e.sw); end
    repeat (2) @(negedge clk);
    sw_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    sw_in[0] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (changed) pulses++;
      if (int'(u_dut.g_bit[0].cnt) > mx) mx = int'(u_dut.g_bit[0].cnt);
      @(negedge clk);
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d want=0", pulses); end
    total++; if (sw_out !== 16'h0000) begin bad++; $display("FAIL glitch_sw got=%h want=0000", sw_out); end
    total++; if (mx !== 3) begin bad++; $display("FAIL glitch_peak got=%0d want=3", mx); end
    total++; if (u_dut.g_bit[0].cnt !== 2'd0) begin bad++; $display("FAIL glitch_cnt got=%0d want=0", u_dut.g_bit[0].cnt); end
  endtask

  task automatic test_clean();
    exp_t e; int at; bit hit;
    drive(16'h0009, 16'h0009, 4'hF);
    e = sbq.pop_front();
    wait_changed(at, hit);
    total++; if (!hit || at !== e.due) begin bad++; $display("FAIL clean_when got=%0d hit=%0b want=%0d", at, hit, e.due); end
    total++; if (sw_out !== e.sw) begin bad++; $display("FAIL clean_sw got=%h want=%h", sw_out, e.sw); end
    total++; if (bcd_ok !== e.ok) begin bad++; $display("FAIL clean_bcd got=%h want=%h", bcd_ok, e.ok); end
    @(negedge clk);
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL clean_pulse got=%b want=0", changed); end
  endtask

  task automatic test_bounce();
    exp_t e; int at; bit hit;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sw_in[4] = (i % 2 == 0);
    end
    drive(16'h0019, 16'h0019, 4'hF);
    e = sbq.pop_front();
    wait_changed(at, hit);
    total++; if (!hit || at !== e.due) begin bad++; $display("FAIL bounce_when got=%0d hit=%0b want=%0d", at, hit, e.due); end
    total++; if (sw_out !== e.sw) begin bad++; $display("FAIL bounce_sw got=%h want=%h", sw_out, e.sw); end
    @(negedge clk);
    total++; if (changed !== 1'b0) begin bad++; $display("FAIL bounce_pulse got=%b want=0", changed); end
  endtask

  task automatic test_bcd();
    exp_t e; int at; bit hit;
    drive(16'h9A05, 16'h9A05, 4'b1011);
    e = sbq.pop_front();
    wait_changed(at, hit);
    total++; if (!hit || at !== e.due) begin bad++; $display("FAIL bcd_a_when got=%0d hit=%0b want=%0d", at, hit, e.due); end
    total++; if (sw_out !== e.sw) begin bad++; $display("FAIL bcd_a_sw got=%h want=%h", sw_out, e.sw); end
    total++; if (bcd_ok !== e.ok) begin bad++; $display("FAIL bcd_a_ok got=%b want=%b", bcd_ok, e.ok); end
    repeat (2) @(negedge clk);
    drive(16'h9105, 16'h9105, 4'b1111);
    e = sbq.pop_front();
    wait_changed(at, hit);
    total++; if (!hit || at !== e.due) begin bad++; $display("FAIL bcd_b_when got=%0d hit=%0b want=%0d", at, hit, e.due); end
    total++; if (sw_out !== e.sw) begin bad++; $display("FAIL bcd_b_sw got=%h want=%h", sw_out, e.sw); end
    total++; if (bcd_ok !== e.ok) begin bad++; $display("FAIL bcd_b_ok got=%b want=%b", bcd_ok, e.ok); end
  endtask

  task automatic test_async_reset();
    exp_t e; int at; bit hit;
    repeat (2) @(negedge clk);
    sw_in = 16'h910D;
    repeat (4) @(negedge clk);
    total++; if (u_dut.g_bit[3].cnt !== 2'd2) begin bad++; $display("FAIL mid_cnt got=%0d want=2", u_dut.g_bit[3].cnt); end
    #1 clr = 1'b1;
    #1;
    total++; if (sw_out !== 16'h0000) begin bad++; $display("FAIL arst_sw got=%h want=0000", sw_out); end
    total++; if (u_dut.g_bit[3].cnt !== 2'd0) begin bad++; $display("FAIL arst_cnt got=%0d want=0", u_dut.g_bit[3].cnt); end
    total++; if (bcd_ok !== 4'hF) begin bad++; $display("FAIL arst_bcd got=%h want=F", bcd_ok); end
    #1 clr = 1'b0;
    e.due = cyc + 1 + LAT; e.sw = 16'h910D; e.ok = 4'b1110;
    sbq.push_back(e);
    e = sbq.pop_front();
    wait_changed(at, hit);
    total++; if (!hit || at !== e.due) begin bad++; $display("FAIL arst_when got=%0d hit=%0b want=%0d", at, hit, e.due); end
    total++; if (sw_out !== e.sw) begin bad++; $display("FAIL arst_resw got=%h want=%h", sw_out, e.sw); end
    total++; if (bcd_ok !== e.ok) begin bad++; $display("FAIL arst_reok got=%b want=%b", bcd_ok, e.ok); end
  endtask

  initial begin
    clr   = 1'b1;
    sw_in = '0;
    test_reset();
    test_glitch();
    test_clean();
    test_bounce();
    test_bcd();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
